palindrome_writer: RTL and testbench

- Producer-side counterpart to the palindrome checker datapath.
- Accepts a stream of words over a valid/ready handshake and mirrors each word into register-file addresses `front` and `back`, converging from both ends.
- The result is that the region `[base, ending]` holds a palindrome.
- Drives a single external regfile write port; the checker later reads the same regfile through its two read ports.

---
 rtl/palindrome_writer_if.sv | 23 ++
 rtl/palindrome_writer.sv | 109 ++++++++++
 tb/tb_palindrome_writer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/palindrome_writer_if.sv
// Word stream into the palindrome writer and the regfile write port it drives.
// master: word source / regfile side; slave: the writer.
interface palindrome_writer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/palindrome_writer.sv
// Mirrors each accepted word to regfile addresses front and back, converging
// inward, so that [base, ending] ends up holding a palindrome.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start; outputs quiet
// ACCEPT     | in_ready high; on handshake write word at front, keep copy
// WRITE_BACK | write held word at back, move both pointers inward
// DONE       | one-cycle done pulse, then back to IDLE
module palindrome_writer #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base,
    input  logic [ADDR_W-1:0]    ending,
    palindrome_writer_if.slave   bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCEPT     = 2'd1,
        WRITE_BACK = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] front;
    logic [ADDR_W-1:0] back;
    logic [WIDTH-1:0]  hold;

    logic              take;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    assign take = (state == ACCEPT) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            front <= '0;
            back  <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        front <= base;
                        back  <= ending;
                        state <= (base > ending) ? DONE : ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid) begin
                        hold  <= bus.in_data;
                        state <= (front == back) ? DONE : WRITE_BACK;
                    end
                end
                WRITE_BACK: begin
                    front <= front + ADDR_W'(1);
                    back  <= back - ADDR_W'(1);
                    // Adjacent pointers mean this back write was the last one.
                    state <= ((back - front) == ADDR_W'(1)) ? DONE : ACCEPT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decode; reset gates them so the reset cycle is quiet
    // even though the state only clears on the following edge.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        if (!reset) begin
            in_ready = (state == ACCEPT);
            busy     = (state != IDLE);
            done     = (state == DONE);
            if (take) begin
                wr_en   = 1'b1;
                wr_addr = front;
                wr_data = bus.in_data;
            end else if (state == WRITE_BACK) begin
                wr_en   = 1'b1;
                wr_addr = back;
                wr_data = hold;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
endmodule

// File: tb/tb_palindrome_writer.sv
// Directed bench for palindrome_writer: fills, degenerate ranges,
// backpressure, ignored start while busy and mid-fill reset.
module tb_palindrome_writer;
    localparam int W = 32;
    localparam int A = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [A-1:0]  base;
    logic [A-1:0]  ending;
    logic          busy;
    logic          done;

    palindrome_writer_if #(.WIDTH(W), .ADDR_W(A)) bus ();

    palindrome_writer #(.WIDTH(W), .ADDR_W(A)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .base   (base),
        .ending (ending),
        .bus    (bus.slave),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [A-1:0] wa[$];
    logic [W-1:0] wd[$];
    int           wc[$];
    int           hs;
    int           done_cyc;
    int           ready_cnt;
    logic         r_busy, r_wr, r_rdy;
    logic [W-1:0] mem[32];
    bit           touched[32];

    // Runs one fill cycle by cycle; cycle 0 is the start cycle. vmask bit k-1
    // gives in_valid for cycle k (held high beyond cycle 8).
    task automatic fill(input logic [A-1:0] b, input logic [A-1:0] e,
                        input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input logic [W-1:0] w2, input logic [W-1:0] w3,
                        input logic [7:0] vmask, input int busy_start_cyc,
                        input int reset_cyc, input int limit);
        logic [W-1:0] words[4];
        words = '{w0, w1, w2, w3};
        wa.delete(); wd.delete(); wc.delete();
        hs = 0; done_cyc = -1; ready_cnt = 0;
        base = b; ending = e; start = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            bus.in_valid = (k <= 8) ? vmask[k-1] : 1'b1;
            bus.in_data  = words[(hs < 4) ? hs : 3];
            if (k == busy_start_cyc) begin
                start = 1'b1; base = 5'd20; ending = 5'd25;
            end else begin
                start = 1'b0;
            end
            reset = (k == reset_cyc);
            @(negedge clk);
            if (reset) begin
                r_busy = busy; r_wr = bus.wr_en; r_rdy = bus.in_ready;
            end
            if (bus.wr_en) begin
                wa.push_back(bus.wr_addr);
                wd.push_back(bus.wr_data);
                wc.push_back(k);
                mem[bus.wr_addr] = bus.wr_data;
                touched[bus.wr_addr] = 1'b1;
            end
            if (bus.in_ready) ready_cnt++;
            if (bus.in_valid && bus.in_ready) hs++;
            if (done) done_cyc = k;
            @(posedge clk); #1;
            if (done_cyc >= 0 || k == reset_cyc) break;
        end
        start = 1'b0; reset = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; base = '0; ending = 5'd7;
        bus.in_valid = 1'b1; bus.in_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_even_fill();
        logic [A-1:0] ea[8] = '{5'd0, 5'd7, 5'd1, 5'd6, 5'd2, 5'd5, 5'd3, 5'd4};
        logic [W-1:0] ed[8] = '{32'd11, 32'd11, 32'd22, 32'd22, 32'd33, 32'd33, 32'd44, 32'd44};
        fill(5'd0, 5'd7, 32'd11, 32'd22, 32'd33, 32'd44, 8'hFF, 0, 0, 40);
        checks++; if (wa.size() != 8) begin failures++; $display("FAIL even_nwrites got=%0d exp=8", wa.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                failures++;
                if (i < wa.size()) $display("FAIL even_write%0d got=(%0d,%0d) exp=(%0d,%0d)", i, wa[i], wd[i], ea[i], ed[i]);
                else $display("FAIL even_write%0d got=none exp=(%0d,%0d)", i, ea[i], ed[i]);
            end
        end
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL even_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (hs != 4) begin failures++; $display("FAIL even_handshakes got=%0d exp=4", hs); end
    endtask

    task automatic test_odd_fill();
        logic [A-1:0] ea[5] = '{5'd3, 5'd7, 5'd4, 5'd6, 5'd5};
        logic [W-1:0] ed[5] = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd7};
        fill(5'd3, 5'd7, 32'd5, 32'd6, 32'd7, 32'd0, 8'hFF, 0, 0, 40);
        checks++; if (wa.size() != 5) begin failures++; $display("FAIL odd_nwrites got=%0d exp=5", wa.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                failures++;
                if (i < wa.size()) $display("FAIL odd_write%0d got=(%0d,%0d) exp=(%0d,%0d)", i, wa[i], wd[i], ea[i], ed[i]);
                else $display("FAIL odd_write%0d got=none exp=(%0d,%0d)", i, ea[i], ed[i]);
            end
        end
        checks++; if (done_cyc != 6) begin failures++; $display("FAIL odd_done_cycle got=%0d exp=6", done_cyc); end
        checks++; if (hs != 3) begin failures++; $display("FAIL odd_handshakes got=%0d exp=3", hs); end
    endtask

    task automatic test_degenerate();
        fill(5'd9, 5'd9, 32'h0000_DEAD, 32'd0, 32'd0, 32'd0, 8'hFF, 0, 0, 20);
        checks++;
        if (wa.size() != 1 || wa[0] !== 5'd9 || wd[0] !== 32'h0000_DEAD) begin
            failures++; $display("FAIL single_write got_n=%0d exp=(9,dead)", wa.size());
        end
        checks++; if (done_cyc != 2) begin failures++; $display("FAIL single_done_cycle got=%0d exp=2", done_cyc); end
        fill(5'd10, 5'd4, 32'd1, 32'd2, 32'd3, 32'd4, 8'hFF, 0, 0, 20);
        checks++; if (done_cyc != 1) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=1", done_cyc); end
        checks++; if (wa.size() != 0) begin failures++; $display("FAIL empty_writes got=%0d exp=0", wa.size()); end
        checks++; if (ready_cnt != 0) begin failures++; $display("FAIL empty_in_ready got=%0d exp=0", ready_cnt); end
    endtask

    task automatic test_backpressure();
        logic [A-1:0] ea[4] = '{5'd0, 5'd3, 5'd1, 5'd2};
        logic [W-1:0] ed[4] = '{32'hAAAA_0001, 32'hAAAA_0001, 32'hBBBB_0002, 32'hBBBB_0002};
        int           ec[4] = '{3, 4, 5, 6};
        fill(5'd0, 5'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'd0, 32'd0, 8'b1111_0100, 0, 0, 40);
        checks++; if (wa.size() != 4) begin failures++; $display("FAIL bp_nwrites got=%0d exp=4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i] || wc[i] != ec[i]) begin
                failures++;
                if (i < wa.size()) $display("FAIL bp_write%0d got=(%0d,%h)@%0d exp=(%0d,%h)@%0d", i, wa[i], wd[i], wc[i], ea[i], ed[i], ec[i]);
                else $display("FAIL bp_write%0d got=none exp=(%0d,%h)", i, ea[i], ed[i]);
            end
        end
        checks++; if (done_cyc != 7) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=7", done_cyc); end
        checks++; if (hs != 2) begin failures++; $display("FAIL bp_handshakes got=%0d exp=2", hs); end
        checks++;
        if (mem[0] !== 32'hAAAA_0001 || mem[1] !== 32'hBBBB_0002 || mem[2] !== 32'hBBBB_0002 || mem[3] !== 32'hAAAA_0001) begin
            failures++; $display("FAIL bp_memory got=%h,%h,%h,%h exp=aaaa0001,bbbb0002,bbbb0002,aaaa0001", mem[0], mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_busy_start_and_abort();
        bit hi_touched;
        for (int i = 0; i < 32; i++) touched[i] = 1'b0;
        fill(5'd0, 5'd7, 32'd11, 32'd22, 32'd33, 32'd44, 8'hFF, 2, 4, 40);
        checks++; if (r_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", r_busy); end
        checks++; if (r_wr !== 1'b0) begin failures++; $display("FAIL abort_wr_en got=%b exp=0", r_wr); end
        checks++; if (r_rdy !== 1'b0) begin failures++; $display("FAIL abort_in_ready got=%b exp=0", r_rdy); end
        checks++;
        if (wa.size() != 3 || wa[2] !== 5'd1 || wd[2] !== 32'd22) begin
            failures++; $display("FAIL abort_writes got_n=%0d exp=3 ending (1,22)", wa.size());
        end
        hi_touched = 1'b0;
        for (int i = 20; i < 32; i++) if (touched[i]) hi_touched = 1'b1;
        checks++; if (hi_touched) begin failures++; $display("FAIL busy_start_ignored got=write_at_20plus exp=none"); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL after_abort_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        fill(5'd0, 5'd1, 32'h5A5A_5A5A, 32'd0, 32'd0, 32'd0, 8'hFF, 0, 0, 20);
        checks++;
        if (wa.size() != 2 || wa[0] !== 5'd0 || wd[0] !== 32'h5A5A_5A5A || wa[1] !== 5'd1 || wd[1] !== 32'h5A5A_5A5A) begin
            failures++; $display("FAIL restart_writes got_n=%0d exp=(0,5a5a5a5a),(1,5a5a5a5a)", wa.size());
        end
        checks++; if (done_cyc != 3) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=3", done_cyc); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base = '0; ending = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        test_reset();
        test_even_fill();
        test_odd_fill();
        test_degenerate();
        test_backpressure();
        test_busy_start_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
